// File: rtl/dsp32_pkg.sv
// Shared DSP32 memory-side definitions: port widths and pointer/word types.
package dsp32_pkg;

  localparam int DSP32_ADDR_W = 8;
  localparam int DSP32_DATA_W = 32;

  // Ring pointers carry one extra MSB as the wrap bit.
  typedef logic [DSP32_ADDR_W:0]   dsp32_ptr_t;
  typedef logic [DSP32_DATA_W-1:0] dsp32_word_t;

endpackage

// File: rtl/dsp32_rdq_if.sv
// Word stream from the read-queue engine to the DSP.
interface dsp32_rdq_if #(
  parameter int DATA_W = 32
);

  // A word transfers on a rising edge where m_valid and m_ready are both high.
  // Once m_valid is raised, it and m_data hold until that transfer or a flush.
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/dsp32_rdq_obuf.sv
// Two-entry output FIFO for the read queue; entry 0 drives the stream.
module dsp32_rdq_obuf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  dsp32_rdq_if.master       m,
  output logic [1:0]        occ,
  output logic              pop
);

  logic [1:0]        occ_q;
  logic [DATA_W-1:0] e0;
  logic [DATA_W-1:0] e1;

  assign occ       = occ_q;
  assign pop       = m.m_valid & m.m_ready;
  assign m.m_valid = (occ_q != 2'd0);
  assign m.m_data  = e0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      occ_q <= 2'd0;
    end else begin
      case ({pop, cap_valid})
        2'b11: begin
          // Occupancy is unchanged; the capture lands behind what remains.
          if (occ_q == 2'd2) begin
            e0 <= e1;
            e1 <= cap_data;
          end else begin
            e0 <= cap_data;
          end
        end
        2'b10: begin
          e0    <= e1;
          occ_q <= occ_q - 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd0) e0 <= cap_data;
          else               e1 <= cap_data;
          occ_q <= occ_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dsp32_rdq.sv
// DSP32 read-side ring-buffer consumer: fetches words up to the CPU write pointer.
// Build option DSP32_RDQ_HALFSWAP_EN swaps 16-bit halves of each word at capture.
module dsp32_rdq
  import dsp32_pkg::*;
#(
  parameter int ADDR_W = DSP32_ADDR_W,
  parameter int DATA_W = DSP32_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wp,
  input  logic              flush,
  output logic              mem_ce,
  output logic              mem_oce,
  output logic [ADDR_W-1:0] mem_ad,
  input  logic [DATA_W-1:0] mem_dout,
  dsp32_rdq_if.master       m,
  output logic [ADDR_W:0]   rd_ptr
);

  logic [ADDR_W:0]   wp_q;
  logic [ADDR_W:0]   fp;
  logic [ADDR_W:0]   rd_ptr_q;
  logic              inflight;
  logic [1:0]        occ;
  logic              pop;
  logic [2:0]        load;
  logic              issue;
  logic [DATA_W-1:0] cap_data;

  // Words committed to the buffer after this cycle's pop; keep it below 2.
  assign load  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue = !flush && (fp != wp_q) && (load < 3'd2);

  assign mem_ce  = issue;
  assign mem_oce = 1'b1;
  assign mem_ad  = fp[ADDR_W-1:0];
  assign rd_ptr  = rd_ptr_q;

`ifdef DSP32_RDQ_HALFSWAP_EN
  assign cap_data = {mem_dout[DATA_W/2-1:0], mem_dout[DATA_W-1:DATA_W/2]};
`else
  assign cap_data = mem_dout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q     <= '0;
      fp       <= '0;
      rd_ptr_q <= '0;
      inflight <= 1'b0;
    end else begin
      wp_q <= wp;
      if (flush) begin
        fp       <= wp;
        rd_ptr_q <= wp;
        inflight <= 1'b0;
      end else begin
        if (issue) fp <= fp + (ADDR_W+1)'(1);
        if (pop)   rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
        inflight <= issue;
      end
    end
  end

  dsp32_rdq_obuf #(
    .DATA_W (DATA_W)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cap_valid (inflight),
    .cap_data  (cap_data),
    .m         (m),
    .occ       (occ),
    .pop       (pop)
  );

endmodule

// File: tb/tb_dsp32_rdq.sv
// Directed bench for dsp32_rdq with a RAM model and a stream scoreboard.
module tb_dsp32_rdq;
  import dsp32_pkg::*;

`ifdef DSP32_RDQ_HALFSWAP_EN
  localparam logic [31:0] W0_EXP = 32'h22221111;
`else
  localparam logic [31:0] W0_EXP = 32'h11112222;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  dsp32_ptr_t  wp = '0;
  logic        flush = 1'b0;
  logic        mem_ce;
  logic        mem_oce;
  logic [7:0]  mem_ad;
  dsp32_word_t mem_dout = '0;
  dsp32_ptr_t  rd_ptr;

  dsp32_word_t ram [256];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  dsp32_rdq_if #(.DATA_W(32)) sif ();

  dsp32_rdq u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wp       (wp),
    .flush    (flush),
    .mem_ce   (mem_ce),
    .mem_oce  (mem_oce),
    .mem_ad   (mem_ad),
    .mem_dout (mem_dout),
    .m        (sif.master),
    .rd_ptr   (rd_ptr)
  );

  // Clock / RAM model / watchdog
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_ce) mem_dout <= ram[mem_ad];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_of(input logic [31:0] w);
`ifdef DSP32_RDQ_HALFSWAP_EN
    return {w[15:0], w[31:16]};
`else
    return w;
`endif
  endfunction

  // Monitor: every accepted word is compared against the expected queue
  always @(negedge clk) begin
    if (rst_n && sif.m_valid && sif.m_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL stream_extra: got 0x%0h expected no word", sif.m_data);
      end else begin
        check("stream_data", sif.m_data, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    wp = '0;
    flush = 1'b0;
    sif.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic fill_basic();
    ram[0] = 32'h11112222;
    ram[1] = 32'h33334444;
    ram[2] = 32'h55556666;
    ram[3] = 32'h77778888;
  endtask

  task automatic push_basic();
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_of(ram[i]));
  endtask

  // Stimulus
  initial begin
    int         ce_cnt;
    int         idx;
    logic [7:0] seq [4];
    seq[0] = 8'd254;
    seq[1] = 8'd255;
    seq[2] = 8'd0;
    seq[3] = 8'd1;
    sif.m_ready = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = '0;

    // Reset state with an idle producer
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_mem_ce", 32'(mem_ce), 32'd0);
      check("idle_m_valid", 32'(sif.m_valid), 32'd0);
      check("idle_rd_ptr", 32'(rd_ptr), 32'd0);
    end
    check("reset_m_data", sif.m_data, 32'd0);
    check("reset_mem_oce", 32'(mem_oce), 32'd1);
    check("reset_mem_ad", 32'(mem_ad), 32'd0);

    // Four words streamed with m_ready held high
    fill_basic();
    push_basic();
    sif.m_ready = 1'b1;
    @(posedge clk);
    #1 wp = 9'd4;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("stream_mem_ce", 32'(mem_ce), 32'((k >= 1) && (k <= 4)));
      check("stream_m_valid", 32'(sif.m_valid), 32'((k >= 3) && (k <= 6)));
      check("stream_rd_ptr", 32'(rd_ptr), (k < 4) ? 32'd0 : 32'(k - 3));
      if (k == 1) check("first_mem_ad", 32'(mem_ad), 32'd0);
    end

    // Back-pressure: only two reads issued while m_ready is low
    do_reset();
    push_basic();
    @(posedge clk);
    #1 wp = 9'd4;
    ce_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_ce) ce_cnt++;
    end
    check("stall_ce_count", 32'(ce_cnt), 32'd2);
    check("stall_m_valid", 32'(sif.m_valid), 32'd1);
    check("stall_m_data", sif.m_data, W0_EXP);
    @(posedge clk);
    #1 sif.m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("release_m_valid", 32'(sif.m_valid), 32'(k < 4));
    end
    check("release_rd_ptr", 32'(rd_ptr), 32'd4);

    // Wrap from address 255 to 0 with the pointer MSB toggling
    do_reset();
    ram[254] = 32'hAAAA0001;
    ram[255] = 32'hAAAA0002;
    ram[0]   = 32'hAAAA0003;
    ram[1]   = 32'hAAAA0004;
    @(posedge clk);
    #1;
    wp = 9'd254;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sif.m_ready = 1'b1;
    @(negedge clk);
    check("wrap_start_rd_ptr", 32'(rd_ptr), 32'd254);
    exp_q.push_back(exp_of(32'hAAAA0001));
    exp_q.push_back(exp_of(32'hAAAA0002));
    exp_q.push_back(exp_of(32'hAAAA0003));
    exp_q.push_back(exp_of(32'hAAAA0004));
    @(posedge clk);
    #1 wp = 9'd258;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_ce) begin
        if (idx < 4) check("wrap_mem_ad", 32'(mem_ad), 32'(seq[idx]));
        idx++;
      end
    end
    check("wrap_issue_count", 32'(idx), 32'd4);
    check("wrap_end_rd_ptr", 32'(rd_ptr), 32'd258);

    // Flush with one word buffered and one read in flight
    do_reset();
    fill_basic();
    exp_q.push_back(exp_of(ram[0]));
    @(posedge clk);
    #1 wp = 9'd4;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 sif.m_ready = 1'b1;
    @(negedge clk);
    check("pre_flush_issue", 32'(mem_ce), 32'd1);
    @(posedge clk);
    #1;
    sif.m_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_mem_ce", 32'(mem_ce), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_flush_m_valid", 32'(sif.m_valid), 32'd0);
      check("post_flush_mem_ce", 32'(mem_ce), 32'd0);
      check("post_flush_rd_ptr", 32'(rd_ptr), 32'd4);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
